instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL: parameter RESET_PC, default 0, byte address loaded into fetch PC on reset.
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL: imem_addr  output  `WORD  byte address of request (= fetch PC).
REQ-006 SHALL: imem_gnt  input  1  memory accepts request this cycle.
REQ-007 SHALL: imem_rvalid  input  1  read data valid; never earlier than the cycle after gnt.
REQ-008 SHALL: imem_rdata  input  `INSTR_LEN  returned instruction word.
REQ-009 SHALL: redirect_valid  input  1  flush and restart fetch (branch/exception).
REQ-010 SHALL: redirect_pc  input  `WORD  restart byte address.
REQ-011 SHALL: out_valid  output  1  instruction available to parse stage.
REQ-012 SHALL: out_ready  input  1  parse stage accepts instruction.
REQ-013 SHALL: out_instr  output  `INSTR_LEN  instruction word, bit layout untouched (opcode [31:21] etc.).
REQ-014 SHALL: out_pc  output  `WORD  byte address out_instr was fetched from.

Function
REQ-015 SHALL: state machine states REQ, WAIT, DROP; at most one memory request outstanding.
REQ-016 SHALL: 2-entry FIFO of {instr, pc}; out_valid = (count != 0); out_instr/out_pc = head entry.
REQ-017 SHALL: REQ -- imem_req = (count < 2) && !redirect_valid; imem_addr = fetch_pc.
REQ-018 SHALL: REQ with imem_req && imem_gnt -> WAIT; latch req_pc = fetch_pc; fetch_pc += 4.
REQ-019 SHALL: WAIT -- imem_req = 0; on imem_rvalid push {imem_rdata, req_pc} into FIFO -> REQ.
REQ-020 SHALL: DROP -- imem_req = 0; on imem_rvalid discard data, no push -> REQ.
REQ-021 SHALL: pop on out_valid && out_ready; push and pop in same cycle leave count unchanged.
REQ-022 SHALL: head entry and out_valid held stable while out_valid && !out_ready.
REQ-023 SHALL: redirect_valid has highest priority: count := 0, fetch_pc := {redirect_pc[`WORD-1:2], 2'b00}.
REQ-024 SHALL: redirect in REQ -> stay REQ, no request issued that cycle; first request at new PC next cycle.
REQ-025 SHALL: redirect in WAIT without rvalid -> DROP; with rvalid same cycle -> data discarded, -> REQ.
REQ-026 SHALL: redirect in DROP -> stay DROP (fetch_pc updated); stale response still discarded.
REQ-027 SHALL: pop handshake coinciding with redirect counts as delivered; remaining entries flushed.
REQ-028 SHALL: fetch_pc increment wraps modulo 2^`WORD (all-ones-3 + 4 -> 0), no flag.
REQ-029 SHALL: FIFO never overflows; push never occurs with count == 2 (guaranteed by REQ-017).
REQ-030 SHALL: imem_rvalid in REQ state ignored (protocol error, no state change).

Reset
REQ-031 SHALL: while rst high: state = REQ, fetch_pc = RESET_PC, count = 0, out_valid = 0, imem_req = 0, out_instr = 0, out_pc = 0.
REQ-032 SHALL: rst mid-transaction abandons outstanding request; a late rvalid after release arrives in REQ and is ignored per REQ-030.
REQ-033 SHALL: first imem_req with imem_addr = RESET_PC in the first cycle after rst deasserts.

Verification
REQ-034 SHALL: reset release, gnt same cycle, rvalid next cycle, out_ready=1, rdata 0x8B020020 -> out_valid with out_instr=0x8B020020, out_pc=0; next imem_addr=4.
REQ-035 SHALL: out_ready=0, memory always responding -> exactly 2 pushes (pc 0, 4), imem_req low while count=2; raising out_ready drains 0 then 4 then resumes at 8.
REQ-036 SHALL: redirect_pc=0x103 in WAIT, rvalid two cycles later -> response dropped, FIFO empty, next imem_addr=0x100, out_pc=0x100 on next output.
REQ-037 SHALL: redirect coincident with rvalid and a pop -> popped entry delivered, rvalid data discarded, count=0, next request at redirect address.
REQ-038 SHALL: redirect_pc=all-ones-3 -> fetches at 0xFF..FC then 0x0 (wrap).
REQ-039 SHALL: rst asserted in WAIT -> all outputs at REQ-031 values asynchronously; late rvalid after release produces no output.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding imem read, 2-entry {instr, pc} buffer
// toward the parse stage, and redirect/flush handling for branches and exceptions.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_fetch #(
   parameter logic [`WORD-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [`WORD-1:0]      imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [`INSTR_LEN-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [`WORD-1:0]      redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [`INSTR_LEN-1:0] out_instr,
   output logic [`WORD-1:0]      out_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   typedef struct packed {
      logic [`INSTR_LEN-1:0] instr;
      logic [`WORD-1:0]      pc;
   } fetch_entry_t;

   state_t           state;
   logic [`WORD-1:0] fetch_pc;
   logic [`WORD-1:0] req_pc;
   logic [`WORD-1:0] redirect_base;
   fetch_entry_t     fifo_q [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign redirect_base = {redirect_pc[`WORD-1:2], 2'b00};

   // rst gates the request so it stays low for the whole reset window
   assign imem_req  = !rst && (state == S_REQ) && (count < 2'd2) && !redirect_valid;
   assign imem_addr = fetch_pc;

   assign out_valid = (count != 2'd0);
   assign out_instr = fifo_q[rd_ptr].instr;
   assign out_pc    = fifo_q[rd_ptr].pc;

   assign pop  = out_valid && out_ready;
   assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_base;
               end else if (imem_req && imem_gnt) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + `WORD'(4);
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_base;
                  state    <= imem_rvalid ? S_REQ : S_DROP;
               end else if (imem_rvalid) begin
                  state <= S_REQ;
               end
            end
            S_DROP: begin
               if (redirect_valid) fetch_pc <= redirect_base;
               if (imem_rvalid)    state    <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // A pop coinciding with a redirect has already been consumed downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else if (redirect_valid) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{instr: imem_rdata, pc: req_pc};
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a transaction-level memory/stream model feeds an
// expected-output queue that a negedge monitor drains against the DUT outputs.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_fetch;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   // Abstract fetch model: next address of the stream plus the one pending read
   logic [63:0] next_addr;
   logic [63:0] outst_addr;
   logic [63:0] last_addr;
   bit          outst;
   bit          drop;
   bit          last_fire;
   int          delay;
   bit          hit;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h8B02_0020;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         exp_t e;
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_instr", 64'(out_instr), 64'(e.instr));
            chk("out_pc", out_pc, e.pc);
         end
      end
   end

   // Account for what the edge just taken did to the stream
   task automatic adv();
      @(posedge clk);
      #1;
      if (imem_rvalid && outst) begin
         if (!drop && !redirect_valid) q.push_back('{mem_word(outst_addr), outst_addr});
         outst = 0;
      end
      if (redirect_valid) begin
         q.delete();
         drop      = outst;
         next_addr = {redirect_pc[63:2], 2'b00};
      end else if (last_fire) begin
         next_addr = next_addr + 64'd4;
      end
      if (last_fire) begin
         outst      = 1;
         drop       = 0;
         outst_addr = last_addr;
         delay      = int'($urandom_range(1, 3));
      end
   endtask

   task automatic drv(input bit redir, input logic [63:0] rpc, input bit rdy,
                      input int unsigned gnt_pct);
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = rdy;
      imem_rvalid    = 1'b0;
      imem_gnt       = 1'b0;
      if (outst) begin
         if (delay <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = (drop || redir) ? ~mem_word(outst_addr) : mem_word(outst_addr);
         end else begin
            delay--;
         end
      end
      #1;
      chk("imem_req", 64'(imem_req), 64'(!outst && q.size() < 2 && !redir));
      if (imem_req) chk("imem_addr", imem_addr, next_addr);
      imem_gnt  = imem_req && ($urandom_range(0, 99) < gnt_pct);
      last_fire = imem_req && imem_gnt;
      last_addr = imem_addr;
   endtask

   task automatic drv_rand();
      drv($urandom_range(0, 99) < 5, {$urandom, $urandom}, $urandom_range(0, 99) < 70, 60);
   endtask

   task automatic do_reset(input bit late_rvalid);
      #1 rst = 1'b1;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      out_ready      = 1'b0;
      #1;
      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      q.delete();
      outst     = 0;
      drop      = 0;
      last_fire = 0;
      next_addr = RESET_PC;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      imem_rvalid = late_rvalid;
      imem_rdata  = 32'hDEAD_BEEF;
      out_ready   = 1'b1;
      #1;
      chk("first_req", 64'(imem_req), 64'd1);
      chk("first_addr", imem_addr, RESET_PC);
      imem_gnt  = 1'b1;
      last_fire = imem_req;
      last_addr = imem_addr;
   endtask

   initial begin
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      outst = 0; drop = 0; last_fire = 0; delay = 0; next_addr = RESET_PC;

      // Reset release with grant in the first cycle, consumer always ready
      do_reset(1'b0);
      repeat (10) begin adv(); drv(0, '0, 1, 100); end

      // Back-pressure: buffer fills to two and requests stop, then drains
      repeat (12) begin adv(); drv(0, '0, 0, 100); end
      repeat (12) begin adv(); drv(0, '0, 1, 100); end

      // Redirect to an unaligned address while a read is in flight
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         adv();
         if (outst && !drop) begin drv(1, 64'h103, 1, 100); hit = 1; end
         else drv(0, '0, 1, 100);
      end
      chk("redirect_wait_hit", 64'(hit), 64'd1);
      repeat (12) begin adv(); drv(0, '0, 1, 100); end

      // Wrap of the fetch address past the top of the address space
      adv(); drv(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 100);
      repeat (12) begin adv(); drv(0, '0, 1, 100); end

      // Redirect in the same cycle as a response and a pop
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         adv();
         if (outst && !drop && delay <= 1 && q.size() > 0) begin
            drv(1, {$urandom, $urandom}, 1, 100);
            hit = 1;
         end else begin
            drv(0, '0, 0, 100);
         end
      end
      chk("redirect_pop_hit", 64'(hit), 64'd1);
      repeat (8) begin adv(); drv(0, '0, 1, 100); end

      repeat (1500) begin adv(); drv_rand(); end

      // Reset in the middle of a read, followed by a late response
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         adv();
         if (outst && !drop && delay > 1) hit = 1;
         drv(0, '0, 1, 100);
      end
      chk("reset_wait_hit", 64'(hit), 64'd1);
      do_reset(1'b1);
      repeat (40) begin adv(); drv_rand(); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
